// File: rtl/sm_color_uart_reporter.sv
// ============================================================================
//  Module   : sm_color_uart_reporter
//  Purpose  : Reports confirmed colour detections as 6-byte "SM-x-#" 8N1
//             UART frames, with a one-deep newest-wins pending request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_color_uart_reporter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       red_led,
    input  logic       green_led,
    input  logic       blue_led,
    output logic       tx,
    output logic       busy,
    output logic [1:0] last_color,
    output logic [7:0] msg_count
);

    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  C_BYTE_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [15:0] r_bit_cnt;
    logic [15:0] w_bit_cnt_n;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_n;
    logic [2:0]  r_byte_idx;
    logic [2:0]  w_byte_idx_n;
    logic [1:0]  r_frame_color;
    logic [1:0]  w_frame_color_n;
    logic [7:0]  r_msg_count;
    logic [7:0]  w_msg_count_n;
    logic        r_tx;
    logic        w_tx_n;
    logic [7:0]  w_byte_n;

    logic [1:0]  r_last_color;
    logic        r_pending;
    logic [1:0]  r_pend_color;
    logic [1:0]  w_code;
    logic        w_invalid;
    logic        w_event;
    logic        w_frame_start;
    logic        w_bit_done;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [1:0] color);
        logic [7:0] b;
        b = 8'h23;
        case (idx)
            3'd0:    b = 8'h53;
            3'd1:    b = 8'h4D;
            3'd2:    b = 8'h2D;
            3'd3: begin
                case (color)
                    2'd1:    b = 8'h52;
                    2'd2:    b = 8'h47;
                    2'd3:    b = 8'h42;
                    default: b = 8'h3F;
                endcase
            end
            3'd4:    b = 8'h2D;
            default: b = 8'h23;
        endcase
        return b;
    endfunction

    always_comb begin
        w_code    = 2'd0;
        w_invalid = 1'b0;
        case ({red_led, green_led, blue_led})
            3'b000:  w_code = 2'd0;
            3'b100:  w_code = 2'd1;
            3'b010:  w_code = 2'd2;
            3'b001:  w_code = 2'd3;
            default: w_invalid = 1'b1;
        endcase
    end

    assign w_event       = !w_invalid && (w_code != 2'd0) && (w_code != r_last_color);
    assign w_frame_start = (r_state == S_IDLE) && r_pending;
    assign w_bit_done    = (r_bit_cnt == C_BIT_LAST);

    // A valid decode always becomes last_color: a repeat leaves it unchanged,
    // "none" clears it so the same colour can be reported again later.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_last_color <= 2'd0;
            r_pending    <= 1'b0;
            r_pend_color <= 2'd0;
        end else begin
            if (!w_invalid) begin
                r_last_color <= w_code;
            end
            if (w_event) begin
                r_pending    <= 1'b1;
                r_pend_color <= w_code;
            end else if (w_frame_start) begin
                r_pending    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_byte_idx    <= 3'd0;
            r_frame_color <= 2'd0;
            r_msg_count   <= 8'd0;
            r_tx          <= 1'b1;
        end else begin
            r_state       <= w_state_n;
            r_bit_cnt     <= w_bit_cnt_n;
            r_bit_idx     <= w_bit_idx_n;
            r_byte_idx    <= w_byte_idx_n;
            r_frame_color <= w_frame_color_n;
            r_msg_count   <= w_msg_count_n;
            r_tx          <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n       = r_state;
        w_bit_cnt_n     = r_bit_cnt;
        w_bit_idx_n     = r_bit_idx;
        w_byte_idx_n    = r_byte_idx;
        w_frame_color_n = r_frame_color;
        w_msg_count_n   = r_msg_count;
        w_tx_n          = 1'b1;
        w_byte_n        = 8'hFF;

        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_state_n       = S_START;
                    w_bit_cnt_n     = 16'd0;
                    w_bit_idx_n     = 3'd0;
                    w_byte_idx_n    = 3'd0;
                    w_frame_color_n = r_pend_color;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_n   = S_DATA;
                    w_bit_cnt_n = 16'd0;
                    w_bit_idx_n = 3'd0;
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_bit_cnt_n = 16'd0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_done) begin
                    w_bit_cnt_n = 16'd0;
                    if (r_byte_idx < C_BYTE_LAST) begin
                        w_state_n    = S_START;
                        w_byte_idx_n = r_byte_idx + 3'd1;
                    end else begin
                        w_state_n     = S_IDLE;
                        w_msg_count_n = r_msg_count + 8'd1;
                    end
                end else begin
                    w_bit_cnt_n = r_bit_cnt + 16'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // tx is registered from the next state so the line is glitch-free
        w_byte_n = frame_byte(w_byte_idx_n, w_frame_color_n);
        case (w_state_n)
            S_START: w_tx_n = 1'b0;
            S_DATA:  w_tx_n = w_byte_n[w_bit_idx_n];
            default: w_tx_n = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign last_color = r_last_color;
    assign msg_count  = r_msg_count;

endmodule

`default_nettype wire

// File: tb/tb_sm_color_uart_reporter.sv
// ============================================================================
//  Module   : tb_sm_color_uart_reporter
//  Purpose  : Self-checking bench: UART byte monitor plus expected-byte queue.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sm_color_uart_reporter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       red, green, blue;
    logic       tx, busy;
    logic [1:0] last_color;
    logic [7:0] msg_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         rst_epoch = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_msg = 8'd0;

    always #5 clk = ~clk;

    sm_color_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50M    (clk),
        .rst_n      (rst_n),
        .red_led    (red),
        .green_led  (green),
        .blue_led   (blue),
        .tx         (tx),
        .busy       (busy),
        .last_color (last_color),
        .msg_count  (msg_count)
    );

    always @(negedge rst_n) rst_epoch = rst_epoch + 1;

    // Sample each bit in its middle; bytes cut short by reset are dropped
    initial begin : uart_monitor
        logic [7:0] b;
        int         ep;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ep = rst_epoch;
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (ep == rst_epoch) rx_q.push_back((tx === 1'b1) ? b : 8'hxx);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic set_leds(input logic r, input logic g, input logic b);
        @(negedge clk);
        red = r; green = g; blue = b;
    endtask

    task automatic push_frame(input logic [7:0] c);
        exp_q.push_back(8'h53); exp_q.push_back(8'h4D); exp_q.push_back(8'h2D);
        exp_q.push_back(c);     exp_q.push_back(8'h2D); exp_q.push_back(8'h23);
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int cnt = 0;
        while (rx_q.size() < n && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int cnt = 0;
        while (busy !== 1'b0 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0; red = 1'b0; green = 1'b0; blue = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || last_color !== 2'd0 || msg_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values got tx=%b busy=%b lc=%0d cnt=%0d want 1 0 0 0", tx, busy, last_color, msg_count);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || msg_count !== 8'd0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_idle got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_red_frame();
        int busy_cycles = 0;
        bit ok;
        logic [7:0] e, a;
        set_leds(1'b1, 1'b0, 1'b0);
        push_frame(8'h52);
        @(negedge clk);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || last_color !== 2'd1) begin
            n_fail++;
            $display("FAIL red_event_edge got tx=%b busy=%b lc=%0d want 1 0 1", tx, busy, last_color);
        end
        @(negedge clk);
        n_tests++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL red_latency got tx=%b busy=%b want 0 1", tx, busy);
        end
        while (busy === 1'b1 && busy_cycles < 1000) begin
            busy_cycles++;
            @(negedge clk);
        end
        n_tests++;
        if (busy_cycles != 60 * CPB) begin
            n_fail++;
            $display("FAIL red_busy_len got %0d want %0d", busy_cycles, 60 * CPB);
        end
        exp_msg++;
        n_tests++;
        if (msg_count !== exp_msg || last_color !== 2'd1) begin
            n_fail++;
            $display("FAIL red_counts got cnt=%0d lc=%0d want %0d 1", msg_count, last_color, exp_msg);
        end
        wait_rx(exp_q.size(), ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL red_rx_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL red_byte got %h want %h", a, e);
            end
        end
    endtask

    task automatic test_hold_and_repeat();
        int bad = 0;
        bit ok, ok2;
        logic [7:0] e, a;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0 || msg_count !== exp_msg) begin
            n_fail++;
            $display("FAIL hold_no_frame got bad=%0d cnt=%0d want 0 %0d", bad, msg_count, exp_msg);
        end
        set_leds(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (last_color !== 2'd0) begin
            n_fail++;
            $display("FAIL none_clears got %0d want 0", last_color);
        end
        set_leds(1'b1, 1'b0, 1'b0);
        push_frame(8'h52);
        wait_rx(exp_q.size(), ok);
        wait_idle(ok2);
        exp_msg++;
        n_tests++;
        if (!ok || !ok2 || msg_count !== exp_msg) begin
            n_fail++;
            $display("FAIL repeat_frame got cnt=%0d rx=%0d want cnt=%0d", msg_count, rx_q.size(), exp_msg);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL repeat_byte got %h want %h", a, e);
            end
        end
        set_leds(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int bad = 0;
        bit ok, ok2;
        logic [7:0] e, a;
        set_leds(1'b1, 1'b0, 1'b0);
        push_frame(8'h52);
        repeat (50) @(negedge clk);
        red = 1'b0; green = 1'b1;
        repeat (5) @(negedge clk);
        green = 1'b0; blue = 1'b1;
        push_frame(8'h42);
        while (busy === 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_end got busy=%b want 0", busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart got busy=%b tx=%b want 1 0", busy, tx);
        end
        wait_rx(exp_q.size(), ok);
        wait_idle(ok2);
        exp_msg = exp_msg + 8'd2;
        n_tests++;
        if (!ok || !ok2 || msg_count !== exp_msg) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want %0d", msg_count, exp_msg);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL b2b_byte got %h want %h", a, e);
            end
        end
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || rx_q.size() != 0 || msg_count !== exp_msg) begin
            n_fail++;
            $display("FAIL b2b_extra_frame got bad=%0d rx=%0d cnt=%0d want 0 0 %0d", bad, rx_q.size(), msg_count, exp_msg);
        end
        set_leds(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_invalid();
        int bad = 0;
        set_leds(1'b1, 1'b0, 1'b1);
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || last_color !== 2'd0 || msg_count !== exp_msg) begin
            n_fail++;
            $display("FAIL invalid_ignored got bad=%0d lc=%0d cnt=%0d want 0 0 %0d", bad, last_color, msg_count, exp_msg);
        end
        set_leds(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int cnt = 0;
        bit ok, ok2;
        logic [7:0] e, a;
        set_leds(1'b1, 1'b0, 1'b0);
        while (busy !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        repeat (3 * 10 * CPB + 10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || msg_count !== 8'd0 || last_color !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset got tx=%b busy=%b cnt=%0d lc=%0d want 1 0 0 0", tx, busy, msg_count, last_color);
        end
        red = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
        exp_msg = 8'd0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || msg_count !== 8'd0 || last_color !== 2'd0) begin
            n_fail++;
            $display("FAIL post_abort_hold got tx=%b busy=%b cnt=%0d lc=%0d want 1 0 0 0", tx, busy, msg_count, last_color);
        end
        set_leds(1'b0, 1'b1, 1'b0);
        push_frame(8'h47);
        wait_rx(exp_q.size(), ok);
        wait_idle(ok2);
        exp_msg = 8'd1;
        n_tests++;
        if (!ok || !ok2 || msg_count !== exp_msg || last_color !== 2'd2) begin
            n_fail++;
            $display("FAIL green_after_reset got cnt=%0d lc=%0d want 1 2", msg_count, last_color);
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx_q.pop_front();
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL green_byte got %h want %h", a, e);
            end
        end
        set_leds(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        int errs = 0;
        int cnt;
        bit ok;
        logic [7:0] e, a;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
        exp_msg = 8'd0;
        for (int k = 0; k < 256; k++) begin
            set_leds(k[0] == 1'b0, k[0] == 1'b1, 1'b0);
            push_frame(k[0] ? 8'h47 : 8'h52);
            exp_msg = exp_msg + 8'd1;
            cnt = 0;
            while (msg_count !== exp_msg && cnt < 1000) begin
                @(negedge clk);
                cnt++;
            end
            if (msg_count !== exp_msg) begin
                n_tests++;
                n_fail++;
                $display("FAIL wrap_frame_timeout got cnt=%0d want %0d", msg_count, exp_msg);
                break;
            end
            if (k == 254) begin
                n_tests++;
                if (msg_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255 got %0d want 255", msg_count);
                end
            end
        end
        n_tests++;
        if (msg_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_zero got %0d want 0", msg_count);
        end
        wait_rx(exp_q.size(), ok);
        if (!ok) errs++;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); a = rx_q.pop_front();
            if (a !== e) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL wrap_bytes got %0d bad bytes want 0", errs);
        end
    endtask

    initial begin
        test_reset();
        test_red_frame();
        test_hold_and_repeat();
        test_back_to_back();
        test_invalid();
        test_reset_midframe();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm_color_uart_reporter.md
SM_COLOR_UART_REPORTER -- requirements
Module: sm_color_uart_reporter

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, giving clk_50M cycles per UART bit (115200 baud); legal range 2..65535.
REQ-002 The module SHALL have port clk_50M, input, 1, the single system clock; all flops are clocked on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port red_led, input, 1, the confirmed red detection from the colour-detection stage, synchronous to clk_50M.
REQ-005 The module SHALL have port green_led, input, 1, the confirmed green detection, synchronous to clk_50M.
REQ-006 The module SHALL have port blue_led, input, 1, the confirmed blue detection, synchronous to clk_50M.
REQ-007 The module SHALL have port tx, output, 1, the UART serial line to the XBee: 8N1, LSB first, idle high.
REQ-008 The module SHALL have port busy, output, 1, high while a frame is being shifted out.
REQ-009 The module SHALL have port last_color, output, 2, the colour most recently accepted for reporting: 0 none, 1 red, 2 green, 3 blue.
REQ-010 The module SHALL have port msg_count, output, 8, the number of frames fully transmitted, wrapping 255 to 0.

Function
REQ-011 The colour inputs SHALL be decoded each cycle: exactly one high gives code 1/2/3, all low gives code 0 (none), and two or more high gives invalid.
REQ-012 An invalid decode SHALL be ignored entirely; last_color and the pending state SHALL hold.
REQ-013 A report event SHALL occur on a cycle whose decoded code is 1..3 and differs from last_color; on that cycle's edge last_color SHALL take the code and a pending request SHALL set.
REQ-014 A decoded code of 0 SHALL set last_color to 0 on the next edge without generating an event, so that the same colour seen again later is reported again.
REQ-015 The pending request SHALL be one deep; a new event while pending is already set SHALL overwrite the pending colour (newest wins) and SHALL NOT be counted twice.
REQ-016 The frame SHALL be 6 bytes: 'S'(0x53), 'M'(0x4D), '-'(0x2D), colour char ('R' 0x52 / 'G' 0x47 / 'B' 0x42), '-'(0x2D), '#'(0x23).
REQ-017 The colour char SHALL be latched when the frame starts; events during transmission SHALL affect only pending, never the frame in flight.
REQ-018 The transmitter FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-019 IDLE SHALL go to START, clear pending and load byte 0 when pending is set.
REQ-020 START SHALL drive tx low for CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA SHALL drive bit[i] for CLKS_PER_BIT cycles, for i = 0..7, then go to STOP.
REQ-022 STOP SHALL drive tx high for CLKS_PER_BIT cycles; it SHALL then go to START with the byte index incremented if the index is below 5, else go to IDLE and increment msg_count.
REQ-023 Latency SHALL be fixed: tx first goes low exactly 2 clocks after the first edge at which the new colour is sampled (event edge plus IDLE-to-START edge).
REQ-024 A frame SHALL last exactly 60*CLKS_PER_BIT cycles from the start-bit falling edge to the end of the last stop bit, with no inter-byte gap.
REQ-025 busy SHALL be high from entry to START for byte 0 until return to IDLE; if pending is set at the end of a frame, the next frame SHALL begin on the following clock.
REQ-026 The bit-timing counter SHALL be 16 bits wide, reload to 0 on every bit boundary, and never wrap within a bit.

Reset
REQ-027 Assertion of rst_n low SHALL immediately force tx=1, busy=0, last_color=0, msg_count=0, FSM=IDLE, pending=0, and all counters to 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame, return tx high immediately, and not count the frame.
REQ-029 After release, outputs SHALL hold their reset values until the first qualifying event.

Verification (CLKS_PER_BIT=4)
REQ-030 Pulse red_led high and hold -> tx low 2 clocks later; the bytes 53 4D 2D 52 2D 23 are decoded; busy high for 240 clocks; msg_count=1, last_color=1.
REQ-031 Hold red, go to none, then red again after the frame -> two frames, msg_count=2; holding red continuously yields only one frame.
REQ-032 During a red frame, drive green and then blue before it ends -> exactly one following frame with 'B', starting 1 clock after the first frame ends; msg_count=2.
REQ-033 Drive red and blue high simultaneously from idle -> no frame, tx stays 1, last_color stays 0.
REQ-034 Assert rst_n low during byte 3 of a frame -> tx=1 and busy=0 asynchronously, msg_count=0; after release plus a green event, a complete 'G' frame is sent.
REQ-035 Send 256 frames by alternating colours -> msg_count wraps to 0.
